pipe_hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage MIPS core. Handles three events:
  - load-use stalls;
  - taken-BEQ flushes;
  - undefined-instruction exceptions raised by the EX-stage ALU control decoder.
- Drives the PC/IF-ID write enables, the per-stage flushes and the PC source select.
- Captures EPC and cause on an exception.
- Sits beside the datapath and owns no datapath registers except EPC/cause.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared state, pc_sel and cause encodings for the hazard sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EXC_DRAIN = 2'd1,
        EXC_VEC   = 2'd2
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_EXC = 2'b10;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_UNDEF = 2'b01;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Flags a LW in EX whose destination is read by the instruction in ID.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    output logic       stall
);

    logic w_dst_live;
    logic w_src_match;

    // $zero is hard-wired, so a load targeting it can never create a hazard
    assign w_dst_live  = (EX_rt != 5'd0);
    assign w_src_match = (EX_rt == ID_rs) || (EX_rt == ID_rt);
    assign stall       = EX_MemRead && w_dst_live && w_src_match;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush/exception sequencer for the 5-stage MIPS pipeline.
//            Define PIPE_PERF_CNT_EN to add stall/flush/exception counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ID_rs,
    input  logic [4:0]      ID_rt,
    input  logic            EX_MemRead,
    input  logic [4:0]      EX_rt,
    input  logic            EX_undefine,
    input  logic [PC_W-1:0] EX_pc,
    input  logic            MEM_branch_taken,
    output logic            pc_write,
    output logic            IFID_write,
    output logic            IFID_flush,
    output logic            IDEX_flush,
    output logic            EXMEM_flush,
    output logic [1:0]      pc_sel,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause,
    output logic            exc_busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
    output logic [31:0]     exc_cnt
`endif
);

    // The vector itself is muxed in the datapath; only its alignment matters here
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_vec_align_chk
        $error("EXC_VECTOR must be word aligned");
    end

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_epc;
    logic [1:0]      r_cause;
    logic            w_stall;
    logic            w_exc_entry;
    logic            w_bubble;
    logic            w_br_flush;

    load_use_detect u_load_use_detect (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .EX_MemRead (EX_MemRead),
        .EX_rt      (EX_rt),
        .stall      (w_stall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_epc   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_exc_entry) begin
                r_epc   <= EX_pc;
                r_cause <= CAUSE_UNDEF;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        EXMEM_flush  = 1'b0;
        pc_sel       = PCSEL_SEQ;
        w_exc_entry  = 1'b0;
        w_bubble     = 1'b0;
        w_br_flush   = 1'b0;
        case (r_state)
            RUN: begin
                // Exception beats an older taken branch; branch beats a stall
                if (EX_undefine) begin
                    w_exc_entry  = 1'b1;
                    w_next_state = EXC_DRAIN;
                    pc_write     = 1'b0;
                    IFID_flush   = 1'b1;
                    IDEX_flush   = 1'b1;
                    EXMEM_flush  = 1'b1;
                end else if (MEM_branch_taken) begin
                    w_br_flush  = 1'b1;
                    pc_sel      = PCSEL_BR;
                    IFID_flush  = 1'b1;
                    IDEX_flush  = 1'b1;
                    EXMEM_flush = 1'b1;
                end else if (w_stall) begin
                    w_bubble   = 1'b1;
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_flush = 1'b1;
                end
            end
            EXC_DRAIN: begin
                w_next_state = EXC_VEC;
                pc_write     = 1'b0;
                IFID_write   = 1'b0;
                IFID_flush   = 1'b1;
                IDEX_flush   = 1'b1;
                EXMEM_flush  = 1'b1;
            end
            EXC_VEC: begin
                w_next_state = RUN;
                pc_sel       = PCSEL_EXC;
                IFID_flush   = 1'b1;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    assign epc      = r_epc;
    assign cause    = r_cause;
    assign exc_busy = (r_state != RUN);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_exc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_exc_cnt   <= '0;
        end else begin
            if (w_bubble)    r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_br_flush)  r_flush_cnt <= r_flush_cnt + 32'd1;
            if (w_exc_entry) r_exc_cnt   <= r_exc_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign exc_cnt   = r_exc_cnt;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire
